// File: rtl/mux_pack_pkg.sv
// rtl/mux_pack_pkg.sv - shared constants, state type and lane helper for the mux consumer stages
//
// Purpose: default lane geometry for the mux result packer, the packer FSM
//          state type, and the lane bit-offset helper.
// Ports:   none (package).
package mux_pack_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int LANES_DEF  = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Bit offset of lane k inside a packed word of w-bit lanes.
  function automatic int lane_slice(input int k, input int w = DATA_W_DEF);
    return k * w;
  endfunction

endpackage

// File: rtl/mux_result_packer_if.sv
// rtl/mux_result_packer_if.sv - input/output handshake bundle of the mux result packer
//
// Purpose: groups the tagged input stream, the flush request, the packed output
//          stream and the duplicate-lane error pulse.
// Ports:   master modport - the producer/sink side (drives in_*, flush, out_ready).
//          slave modport  - the packer (drives in_ready, out_*, err_dup).
interface mux_result_packer_if
  import mux_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
);

  localparam int SEL_W = $clog2(LANES);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W*LANES-1:0]   out_data;
  logic [LANES-1:0]          out_mask;
  logic                      err_dup;

  modport master (
    output in_valid, in_data, in_sel, flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask, err_dup
  );

  modport slave (
    input  in_valid, in_data, in_sel, flush, out_ready,
    output in_ready, out_valid, out_data, out_mask, err_dup
  );

endinterface

// File: rtl/mux_pack_out_reg.sv
// rtl/mux_pack_out_reg.sv - valid/ready output register with load, hold and clear
//
// Purpose: one-entry output stage. A load captures the payload and raises valid;
//          the payload holds while valid & ~ready; acceptance clears valid unless
//          a new load lands on the same edge.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          load          - capture load_payload (only while free)
//          load_payload  - payload to capture
//          ready         - downstream accepts the current payload
//          valid/payload - registered output
//          free          - register is empty or is being emptied this cycle
module mux_pack_out_reg
  import mux_pack_pkg::*;
#(
  parameter int W = DATA_W_DEF * LANES_DEF + LANES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_payload,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] payload,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= load_payload;
    end else if (ready) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_result_packer.sv
// rtl/mux_result_packer.sv - packs tag-addressed mux results into one word per lane sweep
//
// Purpose: collects DATA_W-bit results into the lane named by their tag and emits
//          the packed word (with lane mask) once all lanes are filled or a flush
//          arrives with at least one lane written.
// Ports:   clk, rst - clock, synchronous active-high reset
//          bus      - slave side of mux_result_packer_if (input stream, flush,
//                     packed output stream, err_dup pulse)
module mux_result_packer
  import mux_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic clk,
  input  logic rst,
  mux_result_packer_if.slave bus
);

  localparam int WORD_W = DATA_W * LANES;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   asm_data, asm_data_nxt;
  logic [LANES-1:0]    asm_mask, asm_mask_nxt;
  logic                err_dup_q, err_dup_nxt;

  logic                xfer;
  logic [WORD_W-1:0]   wr_data;
  logic [LANES-1:0]    wr_mask;
  logic                complete;

  logic                load;
  logic [WORD_W-1:0]   load_data;
  logic [LANES-1:0]    load_mask;
  logic                out_free;
  logic                out_valid_w;
  logic [WORD_W+LANES-1:0] out_payload;

  // Assembly as it would look after this cycle's transfer; flush uses this view
  // so a lane arriving together with flush is part of the emitted word.
  always_comb begin
    xfer    = bus.in_valid && (state == COLLECT);
    wr_data = asm_data;
    wr_mask = asm_mask;
    if (xfer) begin
      wr_data[lane_slice(int'(bus.in_sel), DATA_W) +: DATA_W] = bus.in_data;
      wr_mask[bus.in_sel] = 1'b1;
    end
    complete = (state == COLLECT) && ((xfer && (&wr_mask)) || (bus.flush && (|wr_mask)));
  end

  always_comb begin
    state_nxt    = state;
    asm_data_nxt = asm_data;
    asm_mask_nxt = asm_mask;
    load         = 1'b0;
    load_data    = asm_data;
    load_mask    = asm_mask;
    err_dup_nxt  = 1'b0;
    case (state)
      COLLECT: begin
        err_dup_nxt  = xfer && asm_mask[bus.in_sel];
        asm_data_nxt = wr_data;
        asm_mask_nxt = wr_mask;
        if (complete) begin
          if (out_free) begin
            // Hand-off straight into the output register; stay collecting.
            load         = 1'b1;
            load_data    = wr_data;
            load_mask    = wr_mask;
            asm_data_nxt = '0;
            asm_mask_nxt = '0;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load         = 1'b1;
          asm_data_nxt = '0;
          asm_mask_nxt = '0;
          state_nxt    = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      asm_data  <= '0;
      asm_mask  <= '0;
      err_dup_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      asm_data  <= asm_data_nxt;
      asm_mask  <= asm_mask_nxt;
      err_dup_q <= err_dup_nxt;
    end
  end

  mux_pack_out_reg #(
    .W(WORD_W + LANES)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_payload ({load_mask, load_data}),
    .ready        (bus.out_ready),
    .valid        (out_valid_w),
    .payload      (out_payload),
    .free         (out_free)
  );

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_payload[WORD_W-1:0];
  assign bus.out_mask  = out_payload[WORD_W+LANES-1:WORD_W];
  assign bus.err_dup   = err_dup_q;

endmodule

// File: tb/tb_mux_result_packer.sv
// tb/tb_mux_result_packer.sv - self-checking bench for mux_result_packer
module tb_mux_result_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_result_packer_if #(.DATA_W(3), .LANES(4)) bus ();

  mux_result_packer #(.DATA_W(3), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  mask;
    logic [11:0] data;
  } word_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    delivered = 0;
  bit    mon_en = 1'b0;

  // Reference model: lanes written since the last emitted word, and the list of
  // completed words not yet taken by the sink (oldest first).
  logic [2:0] m_lane [4];
  logic [3:0] m_mask = 4'h0;
  word_t      q [$];
  logic       exp_dup = 1'b0;
  logic       prev_stall = 1'b0;
  word_t      prev_word;
  int         sz;
  logic       rdy, xf;
  word_t      w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs and inputs are both stable at the falling edge: compare, then
  // advance the model by what the next rising edge must do.
  always @(negedge clk) begin
    if (mon_en) begin
      sz = q.size();
      chk("in_ready", 32'(bus.in_ready), 32'(sz < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(sz >= 1));
      chk("err_dup", 32'(bus.err_dup), 32'(exp_dup));
      if (sz >= 1) begin
        chk("out_data", 32'(bus.out_data), 32'(q[0].data));
        chk("out_mask", 32'(bus.out_mask), 32'(q[0].mask));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_word", 32'({bus.out_mask, bus.out_data}), 32'(prev_word));
      end
      prev_stall = bus.out_valid && !bus.out_ready && !rst;
      prev_word  = {bus.out_mask, bus.out_data};

      if (rst) begin
        q.delete();
        m_mask  = 4'h0;
        exp_dup = 1'b0;
      end else begin
        rdy = (sz < 2);
        if (sz >= 1 && bus.out_ready) begin
          void'(q.pop_front());
          delivered++;
        end
        xf      = bus.in_valid && rdy;
        exp_dup = xf && m_mask[bus.in_sel];
        if (xf) begin
          m_lane[bus.in_sel] = bus.in_data;
          m_mask[bus.in_sel] = 1'b1;
        end
        if (m_mask != 4'h0 && (m_mask == 4'hF || bus.flush)) begin
          w.mask = m_mask;
          w.data = 12'h0;
          for (int k = 0; k < 4; k++)
            if (m_mask[k]) w.data = w.data + (12'(m_lane[k]) << (3 * k));
          q.push_back(w);
          m_mask = 4'h0;
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [2:0] d, input logic f, input logic o);
    rst          = r;
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.flush    = f;
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic o);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, o);
  endtask

  int base;

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 3'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_err_dup", 32'(bus.err_dup), 32'd0);

    // Ordered sweep
    drive(1'b0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b1);
    chk("sweep_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 3'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd3, 3'd6, 1'b0, 1'b1);
    chk("sweep_valid", 32'(bus.out_valid), 32'd1);
    chk("sweep_data", 32'(bus.out_data), 32'h0CCA);
    chk("sweep_mask", 32'(bus.out_mask), 32'hF);
    chk("sweep_dup", 32'(bus.err_dup), 32'd0);
    idle(1'b1);
    chk("sweep_one_cycle", 32'(bus.out_valid), 32'd0);

    // Back-pressure across two sweeps
    drive(1'b0, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 3'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    chk("bp_first", 32'(bus.out_data), 32'h08D1);
    drive(1'b0, 1'b1, 2'd0, 3'd7, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 1'b0);
    chk("bp_ready_mid", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0);
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_data", 32'(bus.out_data), 32'h08D1);
    drive(1'b0, 1'b1, 2'd0, 3'd7, 1'b0, 1'b0);
    chk("bp_hold_ready2", 32'(bus.in_ready), 32'd0);
    idle(1'b1);
    chk("bp_second", 32'(bus.out_data), 32'h0547);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    idle(1'b1);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Flush of a partial word, then flush of an empty one
    drive(1'b0, 1'b1, 2'd0, 3'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    chk("flush_data", 32'(bus.out_data), 32'h0143);
    chk("flush_mask", 32'(bus.out_mask), 32'h5);
    idle(1'b1);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    chk("flush_empty", 32'(bus.out_valid), 32'd0);

    // Duplicate lane
    drive(1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd1, 3'd4, 1'b0, 1'b1);
    chk("dup_pulse", 32'(bus.err_dup), 32'd1);
    drive(1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
    chk("dup_once", 32'(bus.err_dup), 32'd0);
    drive(1'b0, 1'b1, 2'd2, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b1);
    chk("dup_data", 32'(bus.out_data), 32'h0020);
    chk("dup_mask", 32'(bus.out_mask), 32'hF);
    idle(1'b1);

    // Reset mid-word
    drive(1'b0, 1'b1, 2'd0, 3'd5, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'd1, 3'd5, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_mask", 32'(bus.out_mask), 32'd0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 2'(k), 3'd1, 1'b0, 1'b1);
    chk("rst_new_data", 32'(bus.out_data), 32'h0249);
    chk("rst_new_mask", 32'(bus.out_mask), 32'hF);
    idle(1'b1);

    // Random tags, values, flushes and sink stalls
    base = delivered;
    for (int c = 0; c < 40000 && (delivered - base) < 1000; c++) begin
      drive(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0));
    end
    chk("random_words_done", 32'((delivered - base) >= 1000), 32'd1);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("final_empty", 32'(q.size()), 32'd0);
    chk("final_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_result_packer.md
Name: mux_result_packer

Overview:
- Downstream consumer of the 4:1 mux stage.
- Each cycle it accepts one 3-bit mux result tagged with the sel value that produced it, and stores it in the lane given by the tag.
- Once all four lanes are filled (or a flush is requested), it emits one packed 12-bit word over a valid/ready interface.
- It decouples the free-running mux sweep from a back-pressured sink, for example a checker or log writer.

Parameters:
- DATA_W, 3: width of one mux result (lane).
- LANES, 4: number of lanes, one per sel value; the tag width is $clog2(LANES).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  packer can accept in this cycle.
- in_data  input  DATA_W  mux result (dout).
- in_sel  input  2  sel value that produced in_data; selects the lane.
- flush  input  1  emit the partially filled word.
- out_valid  output  1  out_data/out_mask are valid.
- out_ready  input  1  sink accepts the word.
- out_data  output  DATA_W*LANES  packed word; lane k occupies bits [k*DATA_W +: DATA_W].
- out_mask  output  LANES  bit k set means lane k was written.
- err_dup  output  1  one-cycle pulse: a lane was written twice in one word.

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. out_valid=0, out_data=0, out_mask=0, err_dup=0, assembly mask=0, assembly data=0, state=COLLECT. in_ready=1 from the first cycle after reset.
- Reset mid-operation: the partial assembly and any pending output word are discarded. No output handshake completes in the reset cycle.
- Input handshake: a transfer occurs when in_valid & in_ready. On transfer, lane in_sel takes in_data and mask bit in_sel is set.
- Duplicate lane: if the lane's mask bit is already set, the data is overwritten and err_dup pulses the next cycle.
- Word completion: a word is complete when the mask becomes all-ones after a transfer, or when flush=1 with mask≠0.
  - Flush with mask=0 is ignored.
  - Flush coinciding with a transfer includes that transfer's lane.
- States:
  - COLLECT: accepting input. On completion, go to HAND if the output register is free or is being freed this cycle (out_valid & out_ready); otherwise go to HOLD.
  - HAND (single cycle, no wait): the assembly is copied to out_data/out_mask, out_valid is set, the assembly is cleared, and the state returns to COLLECT. This can be implemented as a COLLECT self-transition.
  - HOLD: the completed assembly waits. in_ready=0. Move to COLLECT with a copy when out_valid=0 or out_ready=1.
- Latency: out_valid rises on the clk edge that accepts the completing lane (registered output, 1 cycle after the input is presented). Sustained throughput is one word per LANES input cycles with no bubbles while out_ready=1.
- Output handshake: out_data, out_mask and out_valid are held stable while out_valid & ~out_ready. out_valid clears after acceptance unless a new word loads on the same edge.
- in_ready = (state != HOLD).
- in_sel wrap from 3 to 0 needs no special case; lanes are tag-addressed, not order-addressed.
- Out-of-order tags are legal.

Decomposition:
- Shared package mux_pack_pkg:
  - DATA_W/LANES defaults.
  - State enum {COLLECT, HOLD}.
  - Function lane_slice(k) returning the bit offset.
- One sub-module, mux_pack_out_reg: a valid/ready output register with load/hold/clear. It is reusable by the other mux-consumer stages.

Test Plan:
- Ordered sweep: lanes 0..3 = 2,1,3,6 with out_ready=1 → out_data=12'hCCA, out_mask=4'hF, out_valid for exactly one cycle, err_dup=0.
- Back-pressure: out_ready=0 across two complete sweeps → first word held stable; second assembly completes; in_ready=0 while in HOLD. Raise out_ready → both words delivered in order, then in_ready=1.
- Flush partial: lanes 0=3 and 2=5, then flush → out_data=12'h143, out_mask=4'h5.
- Flush with an empty mask produces no out_valid.
- Duplicate: lanes 1=1, 1=4, 0,2,3=0 → err_dup pulses once; out_data=12'h020 (lane 1=4).
- Reset mid-word: two lanes written, rst=1 for one cycle → out_valid=0, out_mask=0; a following full sweep emits only the new data.
- Random tags/values with random out_ready (1000 words) against a scoreboard model → no lost, duplicated or reordered words; outputs stable during stalls.
